// File: rtl/stack_ctrl.sv
// Downward-growing stack controller driving an external SP register and a
// one-cycle-latency stack memory. Optional peek command: define STACK_CTRL_PEEK_EN.
module stack_ctrl #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             push,
  input  logic             pop,
`ifdef STACK_CTRL_PEEK_EN
  input  logic             peek,
`endif
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [15:0]      sp_next,
  output logic             sp_load,
  output logic [15:0]      mem_addr,
  output logic             mem_wren,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             full,
  output logic             empty,
  output logic             err
);

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    READ    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [15:0]      sp_r, sp_s;
  logic [WIDTH-1:0] data_r, data_s;
  logic             op_peek_r, op_peek_s;
  logic [WIDTH-1:0] dout_r, dout_s;
  logic             dout_valid_r, dout_valid_s;
  logic [15:0]      sp_next_r, sp_next_s;
  logic             sp_load_r, sp_load_s;
  logic [15:0]      mem_addr_r, mem_addr_s;
  logic             mem_wren_r, mem_wren_s;
  logic             full_r, full_s;
  logic             empty_r, empty_s;
  logic             err_r, err_s;
  logic             ready_r, ready_s;
  logic             peek_s;
  logic             push_ok_s, pop_ok_s, peek_ok_s;

`ifdef STACK_CTRL_PEEK_EN
  assign peek_s = peek;
`else
  assign peek_s = 1'b0;
`endif

  // Exactly one command, and only when the stack can honour it, is accepted.
  assign push_ok_s = push & ~pop & ~peek_s & ~full_r;
  assign pop_ok_s  = pop & ~push & ~peek_s & ~empty_r;
  assign peek_ok_s = peek_s & ~push & ~pop & ~empty_r;

  // Next-state and next-output computation; every output is registered below.
  always_comb begin
    state_s      = state_r;
    sp_s         = sp_r;
    data_s       = data_r;
    op_peek_s    = op_peek_r;
    dout_s       = dout_r;
    dout_valid_s = 1'b0;
    sp_next_s    = sp_next_r;
    sp_load_s    = 1'b0;
    mem_addr_s   = mem_addr_r;
    mem_wren_s   = 1'b0;
    err_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (push_ok_s) begin
          sp_s       = sp_r - 16'd1;
          data_s     = din;
          mem_addr_s = sp_r - 16'd1;
          mem_wren_s = 1'b1;
          sp_next_s  = sp_r - 16'd1;
          sp_load_s  = 1'b1;
          state_s    = WRITE;
        end else if (pop_ok_s || peek_ok_s) begin
          mem_addr_s = sp_r;
          op_peek_s  = peek_ok_s;
          state_s    = READ;
        end else if (push || pop || peek_s) begin
          err_s = 1'b1;
        end else begin
          err_s = 1'b0;
        end
      end
      WRITE: begin
        state_s = IDLE;
      end
      READ: begin
        // The SP load pulse must coincide with the CAPTURE cycle.
        if (!op_peek_r) begin
          sp_next_s = sp_r + 16'd1;
          sp_load_s = 1'b1;
        end else begin
          sp_load_s = 1'b0;
        end
        state_s = CAPTURE;
      end
      CAPTURE: begin
        dout_s       = mem_rdata;
        dout_valid_s = 1'b1;
        if (!op_peek_r) begin
          sp_s = sp_r + 16'd1;
        end else begin
          sp_s = sp_r;
        end
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    ready_s = (state_s == IDLE);
    full_s  = (sp_s == 16'd0);
    empty_s = (sp_s == DEPTH_W);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_r      <= IDLE;
      sp_r         <= DEPTH_W;
      data_r       <= {WIDTH{1'b0}};
      op_peek_r    <= 1'b0;
      dout_r       <= {WIDTH{1'b0}};
      dout_valid_r <= 1'b0;
      sp_next_r    <= DEPTH_W;
      sp_load_r    <= 1'b0;
      mem_addr_r   <= 16'd0;
      mem_wren_r   <= 1'b0;
      full_r       <= 1'b0;
      empty_r      <= 1'b1;
      err_r        <= 1'b0;
      ready_r      <= 1'b1;
    end else begin
      state_r      <= state_s;
      sp_r         <= sp_s;
      data_r       <= data_s;
      op_peek_r    <= op_peek_s;
      dout_r       <= dout_s;
      dout_valid_r <= dout_valid_s;
      sp_next_r    <= sp_next_s;
      sp_load_r    <= sp_load_s;
      mem_addr_r   <= mem_addr_s;
      mem_wren_r   <= mem_wren_s;
      full_r       <= full_s;
      empty_r      <= empty_s;
      err_r        <= err_s;
      ready_r      <= ready_s;
    end
  end

  // Strobes are qualified by Resetn so a reset landing on WRITE aborts the store.
  assign mem_wren   = mem_wren_r & Resetn;
  assign sp_load    = sp_load_r & Resetn;
  assign ready      = ready_r;
  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign sp_next    = sp_next_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = data_r;
  assign full       = full_r;
  assign empty      = empty_r;
  assign err        = err_r;

endmodule
